aes_dec: RTL and testbench
==========================

Name: aes_dec

Overview:
- Iterative AES-128 decryption core. It is the inverse-direction companion to the unprotected functional AES-128 encryption core.
- Uses the same start/done interface, the same input-capture timing and the same 128-bit state byte ordering as the encryption core, so benches and netlists can chain the two.
- Processes one round per clock and derives round keys on the fly: forward expansion to round key 10, then the reverse key schedule. No key RAM.

Parameters:
- none. Fixed AES-128: 10 rounds, 128-bit key.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle start pulse
- ciphertext  in  128  input block; sampled one cycle after start
- key  in  128  cipher key; sampled one cycle after start
- plaintext  out  128  decrypted block; valid while done=1, otherwise 0
- done  out  1  high from completion until the next accepted start

Behaviour:
- Byte order for all 128-bit ports is row-major over the AES state matrix.
  - Bits [127:96] = row 0 (s00,s01,s02,s03), bits [95:64] = row 1, and so on.
  - Byte s_rc sits at bit position 127-8*(4r+c).
  - Example: FIPS-197 plaintext 3243f6a8... is presented as 328831E0_435A3137_F6309807_A88DA234.
- Reset (rst_n=0, asynchronous): state=IDLE, done=0, plaintext=0, all internal state/key/round registers cleared. Reset mid-operation aborts the operation; no output appears.
- FSM states: IDLE, CAPT, EXPAND, INIT, ROUND, DONE.
  - IDLE/DONE: start=1 at edge N → CAPT; done cleared at edge N.
  - CAPT: at edge N+1, capture ciphertext into the state register and key into the key register, whatever start is doing → EXPAND, rnd=1.
  - EXPAND: each edge applies the forward key schedule with rcon[rnd] and increments rnd. After 10 edges (N+2..N+11) the key register holds round key 10 → INIT.
  - INIT (edge N+12): state ^= rk10; rnd=10 → ROUND.
  - ROUND (edges N+13..N+22): each edge computes rk_{rnd-1} from rk_rnd by the reverse schedule.
    - w'[j] = w[j]^w[j-1] for j=3..1.
    - w'[0] = w[0]^SubWord(RotWord(w'[3]))^rcon[rnd].
    - state = InvMixColumns(InvSubBytes(InvShiftRows(state)) ^ rk_{rnd-1}), with InvMixColumns omitted when rnd=1. Decrement rnd.
    - After the rnd=1 edge → DONE.
  - DONE: done=1 and plaintext=state from edge N+22, held until the next start is sampled. Total latency is 22 edges from the start edge.
- Inputs are sampled only in CAPT. Values on ciphertext/key at any other time are ignored.
- start while in CAPT/EXPAND/INIT/ROUND is ignored; the operation is not restarted.
- start in DONE: accepted; done falls at that edge and plaintext returns to 0.
- S-box and inverse S-box are combinational: GF(2^8) inversion (poly 0x11B) plus the affine / inverse affine map, with no ROM.
  - 16 inverse S-boxes for the datapath.
  - 4 forward S-boxes shared by the forward and reverse key schedule.
- rcon[1..10] = 01,02,04,08,10,20,40,80,1B,36.
- InvMixColumns coefficients are 0e,0b,0d,09 via xtime chains, all reduced mod 0x11B.
- plaintext is forced to 0 whenever done=0, so intermediate round state never appears on the port.

Test Plan:
1. FIPS-197 vector: start pulse, next cycle ciphertext=3902DC1925DC116A8409850B1DFB9732, key=2B28AB097EAEF7CF15D2154F16A6883C, next cycle inputs=0 → done rises 22 edges after the start edge; plaintext=328831E0435A3137F6309807A88DA234.
2. Capture timing: start with ciphertext=key=all-FF, next cycle ciphertext=66EF88CAE98A4C344B2CFA2BD43B592E and key=0, following cycle inputs=FF → plaintext=0 (the block sampled one cycle after start is used).
3. Busy start: during scenario 1, pulse start at edge N+8 with different data → result unchanged, latency unchanged, done rises exactly once.
4. Back-to-back: issue a start in the cycle done rises (vector 2 after vector 1) → done drops at that edge, plaintext reads 0 until the second done, second result=0.
5. Reset mid-op: assert rst_n=0 at edge N+15 of scenario 1 → done=0 and plaintext=0 immediately (asynchronous); after release, no done appears without a new start; a fresh run of scenario 1 passes.
6. Round trip: 64 random key/plaintext pairs encrypted by the encryption core, ciphertext fed to aes_dec with the same key → recovered plaintext equals the original in every case.

Source files
------------

// File: rtl/aes_dec.sv
// Iterative AES-128 decryption core, one round per clock.
// Round keys are derived on the fly. The core first runs the forward
// schedule up to round key 10, then walks the reverse schedule back to
// round key 0. All 128-bit buses are row-major over the AES state:
// byte s_rc sits at bits [127-8*(4r+c) -: 8].
module aes_dec (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [127:0] ciphertext,
   input  logic [127:0] key,
   output logic [127:0] plaintext,
   output logic         done
);

   typedef enum logic [2:0] {IDLE, CAPT, EXPAND, INIT, ROUND, DONE} fsm_t;

   fsm_t         fsm;
   logic [127:0] blk;        // working cipher state
   logic [127:0] rk;         // current round key
   logic [3:0]   rnd;        // round counter

   logic [31:0]  w0, w1, w2, w3;
   logic [31:0]  sw_in, sw_out;
   logic [31:0]  f0, f1, f2, f3;
   logic [7:0]   rc;
   logic [127:0] fwd_key, rev_key, ark, round_out;

   // ---------------------------------------------------------------
   // GF(2^8) helpers, all reduced modulo x^8+x^4+x^3+x+1 (0x11B)
   // ---------------------------------------------------------------
   function automatic logic [7:0] xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = xtime(x);
      end
      return p;
   endfunction

   // Multiplicative inverse as a^254; zero maps to zero naturally.
   function automatic logic [7:0] gf_inv(input logic [7:0] a);
      logic [7:0] r;
      logic [7:0] x;
      r = 8'h01;
      x = a;
      for (int i = 1; i < 8; i++) begin
         x = gf_mul(x, x);
         r = gf_mul(r, x);
      end
      return r;
   endfunction

   function automatic logic [7:0] sbox(input logic [7:0] a);
      logic [7:0] v;
      v = gf_inv(a);
      return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]} ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
   endfunction

   function automatic logic [7:0] inv_sbox(input logic [7:0] a);
      logic [7:0] t;
      t = {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ 8'h05;
      return gf_inv(t);
   endfunction

   // ---------------------------------------------------------------
   // State-matrix access helpers
   // ---------------------------------------------------------------
   function automatic logic [7:0] get_byte(input logic [127:0] b, input int r, input int c);
      return b[127-8*(4*r+c) -: 8];
   endfunction

   // Column c as a word with row 0 in the most significant byte.
   function automatic logic [31:0] get_col(input logic [127:0] b, input int c);
      return {get_byte(b, 0, c), get_byte(b, 1, c), get_byte(b, 2, c), get_byte(b, 3, c)};
   endfunction

   function automatic logic [127:0] set_col(input logic [127:0] b, input int c, input logic [31:0] w);
      logic [127:0] o;
      o = b;
      for (int r = 0; r < 4; r++)
         o[127-8*(4*r+c) -: 8] = w[31-8*r -: 8];
      return o;
   endfunction

   function automatic logic [127:0] from_cols(input logic [31:0] c0, input logic [31:0] c1,
                                              input logic [31:0] c2, input logic [31:0] c3);
      logic [127:0] o;
      o = '0;
      o = set_col(o, 0, c0);
      o = set_col(o, 1, c1);
      o = set_col(o, 2, c2);
      o = set_col(o, 3, c3);
      return o;
   endfunction

   // InvMixColumns on one column using 0e/0b/0d/09 built from xtime chains.
   function automatic logic [31:0] inv_mix_col(input logic [31:0] w);
      logic [7:0] a [4];
      logic [7:0] m9 [4];
      logic [7:0] mb [4];
      logic [7:0] md [4];
      logic [7:0] me [4];
      logic [7:0] x2, x4, x8;
      for (int i = 0; i < 4; i++) begin
         a[i]  = w[31-8*i -: 8];
         x2    = xtime(a[i]);
         x4    = xtime(x2);
         x8    = xtime(x4);
         m9[i] = x8 ^ a[i];
         mb[i] = x8 ^ x2 ^ a[i];
         md[i] = x8 ^ x4 ^ a[i];
         me[i] = x8 ^ x4 ^ x2;
      end
      return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
              m9[0] ^ me[1] ^ mb[2] ^ md[3],
              md[0] ^ m9[1] ^ me[2] ^ mb[3],
              mb[0] ^ md[1] ^ m9[2] ^ me[3]};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] n);
      case (n)
         4'd1:    return 8'h01;
         4'd2:    return 8'h02;
         4'd3:    return 8'h04;
         4'd4:    return 8'h08;
         4'd5:    return 8'h10;
         4'd6:    return 8'h20;
         4'd7:    return 8'h40;
         4'd8:    return 8'h80;
         4'd9:    return 8'h1b;
         4'd10:   return 8'h36;
         default: return 8'h00;
      endcase
   endfunction

   // Key schedule: one shared SubWord(RotWord()) serves both directions.
   always_comb begin
      w0 = get_col(rk, 0);
      w1 = get_col(rk, 1);
      w2 = get_col(rk, 2);
      w3 = get_col(rk, 3);
      rc = rcon(rnd);
      // Forward expansion feeds w[3]; the reverse step feeds the recovered w'[3].
      sw_in  = (fsm == EXPAND) ? w3 : (w3 ^ w2);
      sw_out = {sbox(sw_in[23:16]), sbox(sw_in[15:8]), sbox(sw_in[7:0]), sbox(sw_in[31:24])}
               ^ {rc, 24'h000000};
      f0 = w0 ^ sw_out;
      f1 = w1 ^ f0;
      f2 = w2 ^ f1;
      f3 = w3 ^ f2;
      fwd_key = from_cols(f0, f1, f2, f3);
      rev_key = from_cols(w0 ^ sw_out, w1 ^ w0, w2 ^ w1, w3 ^ w2);
   end

   // One inverse round: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns.
   always_comb begin
      // NOTE: every combinational output gets a full default first so no path can leave it unassigned (which would infer a latch).
      ark       = '0;
      round_out = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            ark[127-8*(4*r+c) -: 8] = inv_sbox(get_byte(blk, r, (c + 4 - r) % 4))
                                      ^ get_byte(rev_key, r, c);
      round_out = ark;
      // The last round (rnd=1) has no InvMixColumns.
      if (rnd != 4'd1)
         for (int c = 0; c < 4; c++)
            round_out = set_col(round_out, c, inv_mix_col(get_col(ark, c)));
   end

   // Control FSM with registered done/plaintext outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         fsm       <= IDLE;
         blk       <= '0;
         rk        <= '0;
         rnd       <= '0;
         done      <= 1'b0;
         plaintext <= '0;
      end else begin
         case (fsm)
            IDLE, DONE: begin
               if (start) begin
                  fsm       <= CAPT;
                  done      <= 1'b0;
                  plaintext <= '0;
               end
            end
            CAPT: begin
               blk <= ciphertext;
               rk  <= key;
               rnd <= 4'd1;
               fsm <= EXPAND;
            end
            EXPAND: begin
               rk  <= fwd_key;
               rnd <= rnd + 4'd1;
               if (rnd == 4'd10) fsm <= INIT;
            end
            INIT: begin
               blk <= blk ^ rk;
               rnd <= 4'd10;
               fsm <= ROUND;
            end
            ROUND: begin
               blk <= round_out;
               rk  <= rev_key;
               rnd <= rnd - 4'd1;
               if (rnd == 4'd1) begin
                  fsm       <= DONE;
                  done      <= 1'b1;
                  plaintext <= round_out;
               end
            end
            default: fsm <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_aes_dec.sv
// Self-checking bench for aes_dec. Expected plaintexts are pushed to a
// scoreboard queue when a block is issued and popped when done rises.
// Round-trip ciphertexts come from a behavioural AES-128 encryptor.
module tb_aes_dec;

   logic         clk;
   logic         rst_n;
   logic         start;
   logic [127:0] ciphertext;
   logic [127:0] key;
   logic [127:0] plaintext;
   logic         done;

   int           n_assert = 0;
   int           n_fail   = 0;
   int           cyc      = 0;
   int           start_cyc = 0;
   int           rise_cnt = 0;
   int           rises0;
   logic [127:0] sb_q [$];
   logic [7:0]   sbox_t [256];

   localparam logic [127:0] FIPS_PT  = 128'h328831E0_435A3137_F6309807_A88DA234;
   localparam logic [127:0] FIPS_KEY = 128'h2B28AB09_7EAEF7CF_15D2154F_16A6883C;
   localparam logic [127:0] FIPS_CT  = 128'h3902DC19_25DC116A_8409850B_1DFB9732;
   localparam logic [127:0] ZERO_CT  = 128'h66EF88CA_E98A4C34_4B2CFA2B_D43B592E;
   localparam logic [127:0] ALL_FF   = {128{1'b1}};

   aes_dec dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .start      (start),
      .ciphertext (ciphertext),
      .key        (key),
      .plaintext  (plaintext),
      .done       (done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Free-running edge counter for latency measurement.
   always @(posedge clk) cyc <= cyc + 1;

   // Count rising edges of done.
   always @(posedge done) rise_cnt++;

   // Watchdog so the run can never hang.
   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // ---------------- behavioural AES-128 encryptor ----------------
   function automatic logic [7:0] xt(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] v, input int n);
      return (v << n) | (v >> (8 - n));
   endfunction

   // S-box table generated by walking the multiplicative group with generator 3.
   task automatic build_sbox();
      logic [7:0] p, q, x;
      p = 8'h01;
      q = 8'h01;
      do begin
         p = p ^ (p << 1) ^ (p[7] ? 8'h1b : 8'h00);
         q = q ^ (q << 1);
         q = q ^ (q << 2);
         q = q ^ (q << 4);
         if (q[7]) q = q ^ 8'h09;
         x = q ^ rotl8(q, 1) ^ rotl8(q, 2) ^ rotl8(q, 3) ^ rotl8(q, 4);
         sbox_t[p] = x ^ 8'h63;
      end while (p != 8'h01);
      sbox_t[0] = 8'h63;
   endtask

   function automatic logic [127:0] aes_enc(input logic [127:0] pt, input logic [127:0] k);
      logic [31:0]  w [44];
      logic [7:0]   s [4][4];
      logic [7:0]   t [4][4];
      logic [31:0]  tmp;
      logic [7:0]   rc, a0, a1, a2, a3;
      logic [127:0] res;
      rc = 8'h01;
      for (int c = 0; c < 4; c++)
         w[c] = {k[127-8*c -: 8], k[95-8*c -: 8], k[63-8*c -: 8], k[31-8*c -: 8]};
      for (int i = 4; i < 44; i++) begin
         tmp = w[i-1];
         if (i % 4 == 0) begin
            tmp = {sbox_t[tmp[23:16]], sbox_t[tmp[15:8]], sbox_t[tmp[7:0]], sbox_t[tmp[31:24]]}
                  ^ {rc, 24'h000000};
            rc = xt(rc);
         end
         w[i] = w[i-4] ^ tmp;
      end
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            s[r][c] = pt[127-8*(4*r+c) -: 8] ^ w[c][31-8*r -: 8];
      for (int rd = 1; rd <= 10; rd++) begin
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               t[r][c] = sbox_t[s[r][(c + r) % 4]];
         for (int c = 0; c < 4; c++) begin
            a0 = t[0][c]; a1 = t[1][c]; a2 = t[2][c]; a3 = t[3][c];
            if (rd < 10) begin
               s[0][c] = xt(a0) ^ xt(a1) ^ a1 ^ a2 ^ a3;
               s[1][c] = a0 ^ xt(a1) ^ xt(a2) ^ a2 ^ a3;
               s[2][c] = a0 ^ a1 ^ xt(a2) ^ xt(a3) ^ a3;
               s[3][c] = xt(a0) ^ a0 ^ a1 ^ a2 ^ xt(a3);
            end else begin
               s[0][c] = a0; s[1][c] = a1; s[2][c] = a2; s[3][c] = a3;
            end
         end
         for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
               s[r][c] = s[r][c] ^ w[4*rd+c][31-8*r -: 8];
      end
      res = '0;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            res[127-8*(4*r+c) -: 8] = s[r][c];
      return res;
   endfunction

   // ---------------- stimulus / scoreboard tasks ----------------
   // Start cycle drives 'pre', capture cycle drives ct/k, afterwards 'post'.
   task automatic start_op(input logic [127:0] pre, input logic [127:0] ct, input logic [127:0] k,
                           input logic [127:0] post, input logic [127:0] exp_pt);
      start      = 1'b1;
      ciphertext = pre;
      key        = pre;
      tick();
      start_cyc = cyc;
      check("done_clear_on_start", 128'(done), 128'd0);
      check("pt_clear_on_start", plaintext, 128'd0);
      start      = 1'b0;
      ciphertext = ct;
      key        = k;
      sb_q.push_back(exp_pt);
      tick();
      ciphertext = post;
      key        = post;
   endtask

   task automatic wait_done(input string tag);
      logic         leak;
      logic [127:0] exp_pt;
      leak = 1'b0;
      while (done !== 1'b1 && (cyc - start_cyc) < 40) begin
         if (plaintext !== 128'd0) leak = 1'b1;
         tick();
      end
      check({tag, "_pt_zero_busy"}, 128'(leak), 128'd0);
      check({tag, "_done"}, 128'(done), 128'd1);
      check({tag, "_latency"}, 128'(cyc - start_cyc), 128'd22);
      exp_pt = sb_q.pop_front();
      check({tag, "_plaintext"}, plaintext, exp_pt);
   endtask

   // ---------------- directed sequence ----------------
   initial begin
      logic [127:0] pt, k, ct;
      build_sbox();
      rst_n      = 1'b0;
      start      = 1'b0;
      ciphertext = '0;
      key        = '0;
      tick();
      tick();
      check("reset_done", 128'(done), 128'd0);
      check("reset_pt", plaintext, 128'd0);
      rst_n = 1'b1;
      tick();

      // Bench encryptor sanity against the FIPS-197 vector.
      check("model_fips", aes_enc(FIPS_PT, FIPS_KEY), FIPS_CT);

      // 1. FIPS-197 vector.
      start_op('0, FIPS_CT, FIPS_KEY, '0, FIPS_PT);
      wait_done("fips");

      // Asynchronous reset while holding a result: outputs clear before any edge.
      rst_n = 1'b0;
      #1;
      check("async_rst_done", 128'(done), 128'd0);
      check("async_rst_pt", plaintext, 128'd0);
      #2;
      rst_n = 1'b1;
      tick();

      // 2. Capture timing: only the block sampled one cycle after start counts.
      start_op(ALL_FF, ZERO_CT, '0, ALL_FF, '0);
      wait_done("capture");

      // 3. Start pulse while busy is ignored.
      start_op('0, FIPS_CT, FIPS_KEY, '0, FIPS_PT);
      rises0 = rise_cnt;
      repeat (6) tick();
      start      = 1'b1;
      ciphertext = ZERO_CT;
      key        = ALL_FF;
      tick();
      start      = 1'b0;
      ciphertext = '0;
      key        = '0;
      wait_done("busy");
      repeat (5) tick();
      check("busy_done_held", 128'(done), 128'd1);
      check("busy_single_rise", 128'(rise_cnt - rises0), 128'd1);

      // 4. Back-to-back: second start issued in the cycle done rises.
      start_op('0, FIPS_CT, FIPS_KEY, '0, FIPS_PT);
      wait_done("b2b_first");
      start_op(ALL_FF, ZERO_CT, '0, ALL_FF, '0);
      wait_done("b2b_second");

      // 5. Reset mid-operation aborts the run.
      start_op('0, FIPS_CT, FIPS_KEY, '0, FIPS_PT);
      repeat (13) tick();
      @(posedge clk);
      rst_n = 1'b0;
      #1;
      check("abort_done", 128'(done), 128'd0);
      check("abort_pt", plaintext, 128'd0);
      sb_q.delete();
      rises0 = rise_cnt;
      repeat (2) tick();
      rst_n = 1'b1;
      repeat (40) tick();
      check("abort_no_done", 128'(done), 128'd0);
      check("abort_no_rise", 128'(rise_cnt - rises0), 128'd0);
      start_op('0, FIPS_CT, FIPS_KEY, '0, FIPS_PT);
      wait_done("post_reset");

      // 6. Round trip against the behavioural encryptor.
      for (int i = 0; i < 64; i++) begin
         pt = {$urandom, $urandom, $urandom, $urandom};
         k  = {$urandom, $urandom, $urandom, $urandom};
         ct = aes_enc(pt, k);
         start_op({$urandom, $urandom, $urandom, $urandom}, ct, k,
                  {$urandom, $urandom, $urandom, $urandom}, pt);
         wait_done($sformatf("rt%0d", i));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
